// File: rtl/avl_st_video_packer_if.sv
// Avalon-ST streaming bundle shared by the packer sink (24-bit pixels) and source (packed words).
interface avl_st_video_packer_if #(
   parameter int DATA_W = 24
) ();
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;
   logic              sop;
   logic              eop;

   modport master (output data, valid, sop, eop, input ready);
   modport slave  (input data, valid, sop, eop, output ready);
endinterface

// File: rtl/avl_st_video_packer.sv
// Strips the Avalon-ST Video header and drops control packets.
// Packs RGB888/RGB565 pixels into OUT_BYTES-wide words behind a small show-ahead FIFO.
module avl_st_video_packer #(
   parameter int OUT_BYTES  = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_rgb565,
   avl_st_video_packer_if.slave  in_avl_st,
   avl_st_video_packer_if.master out_avl_st,
   output logic                  frame_done,
   output logic [15:0]           ctrl_pkt_cnt
);
   localparam int REG_BYTES = 2 * OUT_BYTES;
   localparam int CNT_W     = $clog2(REG_BYTES + 1);
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int WORD_W    = 8 * OUT_BYTES;
   localparam logic [CNT_W-1:0] OB_C    = CNT_W'(OUT_BYTES);
   localparam logic [CNT_W:0]   RB_C    = (CNT_W+1)'(REG_BYTES);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_VIDEO, S_SKIP, S_FLUSH} state_t;
   typedef struct packed {
      logic              sop;
      logic              eop;
      logic [WORD_W-1:0] data;
   } word_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [REG_BYTES-1:0][7:0] pack_q, pack_d;
   logic                      rgb565_q, rgb565_d;
   logic                      sop_pend_q, sop_pend_d;
   logic                      frame_done_q, frame_done_d;
   logic [15:0]               ctrl_cnt_q, ctrl_cnt_d;
   logic [PTR_W-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PTR_W:0]            fcnt_q, fcnt_d;
   logic                      full_q, full_d;
   word_t                     mem_q [FIFO_DEPTH];

   logic [CNT_W-1:0] bpp, wr_bytes, cnt_left;
   logic [CNT_W:0]   fill_after;
   logic [2:0][7:0]  app;
   logic [15:0]      p565;
   logic             in_ready, acc, wr_en, rd_en, empty;
   word_t            wr_word, rd_word;
   int               idx;

   always_comb begin
      empty    = (fcnt_q == '0);
      rd_en    = !empty && out_avl_st.ready;
      bpp      = rgb565_q ? CNT_W'(2) : CNT_W'(3);
      wr_en    = !full_q && (((state_q == S_VIDEO) && (cnt_q >= OB_C)) ||
                             ((state_q == S_FLUSH) && (cnt_q != '0)));
      wr_bytes = '0;
      if (wr_en) wr_bytes = (cnt_q > OB_C) ? OB_C : cnt_q;
      cnt_left   = cnt_q - wr_bytes;
      fill_after = {1'b0, cnt_left} + {1'b0, bpp};

      in_ready = 1'b0;
      case (state_q)
         S_IDLE, S_SKIP: in_ready = 1'b1;
         S_VIDEO:        in_ready = (fill_after <= RB_C);
         default:        in_ready = 1'b0;
      endcase
      acc = in_avl_st.valid && in_ready;

      // Lanes beyond the live byte count are forced to zero so the flushed tail is padded.
      wr_word.sop  = sop_pend_q;
      wr_word.eop  = (state_q == S_FLUSH) && (cnt_q <= OB_C);
      wr_word.data = '0;
      for (int i = 0; i < OUT_BYTES; i++)
         wr_word.data[8*i +: 8] = (CNT_W'(i) < cnt_q) ? pack_q[i] : 8'h00;

      p565 = {in_avl_st.data[23:19], in_avl_st.data[15:10], in_avl_st.data[7:3]};
      app  = rgb565_q ? {8'h00, p565[15:8], p565[7:0]}
                      : {in_avl_st.data[7:0], in_avl_st.data[15:8], in_avl_st.data[23:16]};

      pack_d = pack_q;
      if (wr_en) begin
         for (int i = 0; i < OUT_BYTES; i++) begin
            pack_d[i]             = pack_q[i+OUT_BYTES];
            pack_d[i+OUT_BYTES]   = 8'h00;
         end
      end
      cnt_d      = cnt_left;
      state_d    = state_q;
      rgb565_d   = rgb565_q;
      ctrl_cnt_d = ctrl_cnt_q;
      sop_pend_d = sop_pend_q && !wr_en;
      idx        = 0;

      case (state_q)
         S_IDLE: if (acc && in_avl_st.sop) begin
            if (in_avl_st.data[3:0] == 4'h0) begin
               if (!in_avl_st.eop) begin
                  state_d    = S_VIDEO;
                  rgb565_d   = cfg_rgb565;
                  sop_pend_d = 1'b1;
               end
            end else begin
               ctrl_cnt_d = ctrl_cnt_q + 16'd1;
               if (!in_avl_st.eop) state_d = S_SKIP;
            end
         end
         S_SKIP: if (acc && in_avl_st.eop) state_d = S_IDLE;
         S_VIDEO: if (acc) begin
            // New bytes land directly after whatever survives this cycle's shift.
            for (int i = 0; i < REG_BYTES; i++) begin
               idx = i - int'(cnt_left);
               if (idx >= 0 && idx < int'(bpp)) pack_d[i] = app[idx[1:0]];
            end
            cnt_d = cnt_left + bpp;
            if (in_avl_st.eop) state_d = S_FLUSH;
         end
         S_FLUSH: if (wr_en && wr_word.eop) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      wptr_d       = wptr_q + PTR_W'(wr_en);
      rptr_d       = rptr_q + PTR_W'(rd_en);
      fcnt_d       = fcnt_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_en);
      full_d       = (fcnt_d == DEPTH_C);
      frame_done_d = wr_en && wr_word.eop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         pack_q       <= '0;
         rgb565_q     <= 1'b0;
         sop_pend_q   <= 1'b0;
         frame_done_q <= 1'b0;
         ctrl_cnt_q   <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         fcnt_q       <= '0;
         full_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pack_q       <= pack_d;
         rgb565_q     <= rgb565_d;
         sop_pend_q   <= sop_pend_d;
         frame_done_q <= frame_done_d;
         ctrl_cnt_q   <= ctrl_cnt_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         fcnt_q       <= fcnt_d;
         full_q       <= full_d;
      end
   end

   // Storage needs no reset: outputs are gated by the occupancy count.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q] <= wr_word;
   end

   assign rd_word                = mem_q[rptr_q];
   assign in_avl_st.ready        = in_ready;
   assign out_avl_st.valid       = !empty;
   assign out_avl_st.data        = empty ? '0 : rd_word.data;
   assign out_avl_st.sop         = !empty && rd_word.sop;
   assign out_avl_st.eop         = !empty && rd_word.eop;
   assign frame_done             = frame_done_q;
   assign ctrl_pkt_cnt           = ctrl_cnt_q;
endmodule

// File: tb/tb_avl_st_video_packer.sv
// Directed bench for avl_st_video_packer (OUT_BYTES=4, FIFO_DEPTH=4) with hand-computed words.
module tb_avl_st_video_packer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_rgb565 = 1'b0;
   logic        frame_done;
   logic [15:0] ctrl_pkt_cnt;

   avl_st_video_packer_if #(.DATA_W(24)) in_if ();
   avl_st_video_packer_if #(.DATA_W(32)) out_if ();

   avl_st_video_packer #(.OUT_BYTES(4), .FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_rgb565   (cfg_rgb565),
      .in_avl_st    (in_if),
      .out_avl_st   (out_if),
      .frame_done   (frame_done),
      .ctrl_pkt_cnt (ctrl_pkt_cnt)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, timeouts = 0, fd_cnt = 0, leak = 0, stall_cnt = 0, rx_rd = 0;
   logic [33:0] rx_q[$];
   logic [33:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Words are captured half a cycle before the edge that consumes them.
   always @(negedge clk) begin
      if (out_if.valid && out_if.ready) rx_q.push_back({out_if.sop, out_if.eop, out_if.data});
      if (!out_if.valid && (out_if.data != 32'h0 || out_if.sop || out_if.eop)) leak++;
      if (frame_done) fd_cnt++;
      if (in_if.valid && !in_if.ready) stall_cnt++;
   end

   task automatic send_beat(input logic [23:0] d, input logic s, input logic e);
      int n = 0;
      in_if.data  = d;
      in_if.sop   = s;
      in_if.eop   = e;
      in_if.valid = 1'b1;
      while (!in_if.ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) timeouts++;
      @(negedge clk);
      in_if.valid = 1'b0;
      in_if.sop   = 1'b0;
      in_if.eop   = 1'b0;
   endtask

   task automatic check_rx(input string tag, input int fd0);
      int n = exp_q.size();
      int k = 0;
      logic [33:0] got;
      while (rx_q.size() - rx_rd < n && k < 1000) begin
         @(negedge clk);
         k++;
      end
      repeat (10) @(negedge clk);
      chk({tag, "_count"}, 64'(rx_q.size() - rx_rd), 64'(n));
      for (int i = 0; i < n; i++) begin
         got = (rx_rd + i < rx_q.size()) ? rx_q[rx_rd + i] : 34'h0;
         chk($sformatf("%s_w%0d", tag, i), 64'(got), 64'(exp_q[i]));
      end
      chk({tag, "_frame_done"}, 64'(fd_cnt - fd0), 64'd1);
      rx_rd = rx_q.size();
      exp_q.delete();
   endtask

   task automatic pkt_four_px();
      send_beat(24'h000000, 1'b1, 1'b0);
      send_beat(24'h112233, 1'b0, 1'b0);
      send_beat(24'h445566, 1'b0, 1'b0);
      send_beat(24'h778899, 1'b0, 1'b0);
      send_beat(24'hAABBCC, 1'b0, 1'b1);
      exp_q.push_back({2'b10, 32'h44332211});
      exp_q.push_back({2'b00, 32'h88776655});
      exp_q.push_back({2'b01, 32'hCCBBAA99});
   endtask

   task automatic pkt_three_px();
      send_beat(24'h000000, 1'b1, 1'b0);
      send_beat(24'h112233, 1'b0, 1'b0);
      send_beat(24'h445566, 1'b0, 1'b0);
      send_beat(24'h778899, 1'b0, 1'b1);
      exp_q.push_back({2'b10, 32'h44332211});
      exp_q.push_back({2'b00, 32'h88776655});
      exp_q.push_back({2'b01, 32'h00000099});
   endtask

   initial begin
      int fd0;
      int s0;
      in_if.valid  = 1'b0;
      in_if.data   = '0;
      in_if.sop    = 1'b0;
      in_if.eop    = 1'b0;
      out_if.ready = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_in_ready",   64'(in_if.ready),   64'd1);
      chk("rst_out_valid",  64'(out_if.valid),  64'd0);
      chk("rst_out_data",   64'(out_if.data),   64'd0);
      chk("rst_out_sop",    64'(out_if.sop),    64'd0);
      chk("rst_out_eop",    64'(out_if.eop),    64'd0);
      chk("rst_frame_done", 64'(frame_done),    64'd0);
      chk("rst_ctrl_cnt",   64'(ctrl_pkt_cnt),  64'd0);
      rst = 1'b0;
      @(negedge clk);

      // RGB888, four pixels: exact multiple of the word width.
      fd0 = fd_cnt;
      pkt_four_px();
      check_rx("t1", fd0);

      // RGB888, three pixels: last word padded with zeros.
      fd0 = fd_cnt;
      pkt_three_px();
      check_rx("t2", fd0);

      // RGB565; cfg changes after the header must not matter.
      fd0 = fd_cnt;
      cfg_rgb565 = 1'b1;
      send_beat(24'h000000, 1'b1, 1'b0);
      cfg_rgb565 = 1'b0;
      send_beat(24'hFF0000, 1'b0, 1'b0);
      send_beat(24'h00FF00, 1'b0, 1'b1);
      exp_q.push_back({2'b11, 32'h07E0F800});
      check_rx("t3", fd0);

      // Stray beat, control packet with payload, header-only control and video packets.
      fd0 = fd_cnt;
      send_beat(24'hDEAD00, 1'b0, 1'b0);
      send_beat(24'h00000F, 1'b1, 1'b0);
      send_beat(24'h123456, 1'b0, 1'b0);
      send_beat(24'h000000, 1'b1, 1'b0);
      send_beat(24'h654321, 1'b0, 1'b0);
      send_beat(24'hABCDEF, 1'b0, 1'b0);
      send_beat(24'h0F0F0F, 1'b0, 1'b1);
      send_beat(24'h000003, 1'b1, 1'b1);
      send_beat(24'h000000, 1'b1, 1'b1);
      pkt_four_px();
      check_rx("t4", fd0);
      chk("t4_ctrl_cnt", 64'(ctrl_pkt_cnt), 64'd2);

      // 16 RGB888 pixels with bytes 0x01..0x30 while the source is held off for 20 cycles.
      fd0 = fd_cnt;
      s0  = stall_cnt;
      fork
         begin
            send_beat(24'h000000, 1'b1, 1'b0);
            for (int k = 0; k < 16; k++)
               send_beat({8'(3*k+1), 8'(3*k+2), 8'(3*k+3)}, 1'b0, k == 15);
         end
         begin
            @(posedge clk);
            #1 out_if.ready = 1'b0;
            repeat (20) @(posedge clk);
            #1 out_if.ready = 1'b1;
         end
      join
      for (int j = 0; j < 12; j++)
         exp_q.push_back({j == 0, j == 11, 8'(4*j+4), 8'(4*j+3), 8'(4*j+2), 8'(4*j+1)});
      check_rx("t5", fd0);
      chk("t5_sink_stalled", 64'(stall_cnt > s0), 64'd1);

      // Reset in the middle of a video packet, then a clean packet.
      send_beat(24'h000000, 1'b1, 1'b0);
      send_beat(24'h010203, 1'b0, 1'b0);
      send_beat(24'h040506, 1'b0, 1'b0);
      send_beat(24'h070809, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_in_ready",   64'(in_if.ready),  64'd1);
      chk("t6_out_valid",  64'(out_if.valid), 64'd0);
      chk("t6_out_data",   64'(out_if.data),  64'd0);
      chk("t6_frame_done", 64'(frame_done),   64'd0);
      chk("t6_ctrl_cnt",   64'(ctrl_pkt_cnt), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rx_rd = rx_q.size();
      fd0   = fd_cnt;
      pkt_three_px();
      check_rx("t6", fd0);

      chk("beat_timeouts",  64'(timeouts), 64'd0);
      chk("valid_low_leak", 64'(leak),     64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/avl_st_video_packer.md
# avl_st_video_packer

Parametrised successor to the 24-to-32 Avalon-ST video packer. It sits between the video scaler/frame-reader output and the DSI packet assembler. It strips the Avalon-ST Video header beat and drops non-video (control) packets. It packs RGB888 or RGB565 pixels into OUT_BYTES-wide words, and zero-pads and flushes the final partial word of every video packet. It also reports per-frame completion and the number of dropped control packets.

## Interface
- OUT_BYTES, 4, output word width in bytes; legal values are 4 and 8.
- FIFO_DEPTH, 4, output FIFO depth in words; power of 2, at least 2.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- cfg_rgb565  in  1  pixel format: 0 = RGB888 (3 bytes per pixel), 1 = RGB565 (2 bytes per pixel). Sampled only on an accepted header beat.
- in_avl_st_data  in  24  one pixel per beat, laid out as R[23:16], G[15:8], B[7:0]; on the header beat, [3:0] is the packet type.
- in_avl_st_valid / in_avl_st_startofpacket / in_avl_st_endofpacket  in  1 each  Avalon-ST sink signals.
- in_avl_st_ready  out  1  sink ready.
- out_avl_st_data  out  OUT_BYTES*8  packed word; the earliest byte is in lane 0 (bits [7:0]).
- out_avl_st_valid / out_avl_st_startofpacket / out_avl_st_endofpacket  out  1 each  source signals.
- out_avl_st_ready  in  1  source ready.
- frame_done  out  1  one-cycle pulse when the eop word of a video packet is written into the FIFO.
- ctrl_pkt_cnt  out  16  count of dropped packets whose type is not 0; wraps at 0xFFFF.

## Operation
- A beat is accepted when in_avl_st_valid and in_avl_st_ready are both high.
- State machine (IDLE, VIDEO, SKIP, FLUSH):
  - IDLE: in_avl_st_ready = 1. Beats without sop are discarded. A beat with sop is the header and is never forwarded.
    - Type 0 without eop: latch cfg_rgb565, set the pending-sop flag, go to VIDEO.
    - Type other than 0: increment ctrl_pkt_cnt, go to SKIP.
    - Header beat with eop: stay in IDLE, emit nothing (for a non-zero type, still increment ctrl_pkt_cnt).
  - SKIP: in_avl_st_ready = 1. All beats are discarded. An accepted beat with eop returns to IDLE.
  - VIDEO: each accepted beat appends 3 or 2 bytes to the pack register.
    - RGB888 byte order: data[23:16], then [15:8], then [7:0].
    - RGB565 pixel: p = {R[7:3], G[7:2], B[7:3]}; byte order p[7:0], then p[15:8].
    - An accepted beat with eop goes to FLUSH.
    - A sop seen in VIDEO is treated as an ordinary payload beat.
  - FLUSH: in_avl_st_ready = 0. Remaining bytes are written out as words, with unused upper lanes zero. The word that empties the register carries eop and pulses frame_done, then the state returns to IDLE. If the register is already empty on entry, the most recent word cannot be retro-tagged, so the eop beat always leaves at least one byte (a video packet has at least one payload beat).
- Pack register:
  - Capacity is 2*OUT_BYTES bytes; byte count `cnt` is 0 to 2*OUT_BYTES.
  - A word write happens when cnt >= OUT_BYTES (or, in FLUSH, cnt > 0) and the FIFO is not full.
  - On a write, the register shifts right by OUT_BYTES bytes (zeros enter) and cnt decreases by min(cnt, OUT_BYTES). An append in the same cycle lands after the shift.
- In VIDEO, in_avl_st_ready = ((cnt - wrbytes) + bpp <= 2*OUT_BYTES), where wrbytes is the number of bytes written this cycle.
- The first word written after the header carries sop; the pending-sop flag clears on that write.
- Output FIFO is show-ahead:
  - out_avl_st_valid = !empty.
  - A read happens on valid && ready.
  - data, sop and eop are forced to 0 while valid is low.
- Simultaneous FIFO read and write when full: the write stalls this cycle (full is a registered flag); no data is lost.

## Timing
- Reset (rst high at a clk edge):
  - state = IDLE, cnt = 0, FIFO empty, ctrl_pkt_cnt = 0.
  - All outputs are 0 except in_avl_st_ready, which is 1 (IDLE).
  - A reset mid-packet discards all buffered data; the next packet must start with a header.
- Latency: the beat completing a word is accepted at edge N, the word is written at edge N+1, and out_avl_st_valid is high in the cycle after edge N+1 (2 clocks).
- Throughput: one word per clock while the sink is not backpressured.
- FLUSH takes ceil(cnt/OUT_BYTES) write cycles, plus any FIFO-full stall cycles.
- frame_done is aligned with the FIFO write edge of the eop word.

## Test plan
- OUT_BYTES = 4, RGB888; header 0x000000, then pixels 0x112233, 0x445566, 0x778899, 0xAABBCC (eop) -> words 0x44332211 (sop), 0x88776655, 0xCCBBAA99 (eop); one frame_done pulse.
- Same, but with 3 pixels ending at 0x778899 (eop) -> 0x44332211 (sop), 0x88776655, 0x00000099 (eop, padded).
- RGB565; header type 0, then pixels 0xFF0000, 0x00FF00 (eop) -> single word 0x07E0F800 with sop = eop = 1.
- Control packet: header 0x00000F plus 5 beats, then a video packet -> no output from the control packet; ctrl_pkt_cnt = 1; the video packet is unaffected.
- Hold out_avl_st_ready = 0 for 20 cycles during a 16-pixel RGB888 packet -> FIFO fills and in_avl_st_ready drops; after release, exactly 12 words arrive in order with no loss or duplication.
- Assert rst in the middle of VIDEO -> all outputs reset the following cycle; a subsequent clean packet produces the correct words.
